// File: rtl/score_pkg.sv
// Shared definitions for the piano score sequencer: entry layout, opcodes,
// silence word and FSM state encodings.
package score_pkg;

    localparam int DUR_W = 10;

    localparam logic [1:0] OP_PLAY = 2'b00;
    localparam logic [1:0] OP_END  = 2'b01;
    localparam logic [1:0] OP_LOOP = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    localparam logic [31:0] SILENCE = 32'h000F_0000;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    // One score entry, MSB first: op[31:30], duration[29:20], hush[19:16], notes[15:0]
    typedef struct packed {
        logic [1:0]       op;
        logic [DUR_W-1:0] dur;
        logic [3:0]       hush;
        logic [15:0]      notes;
    } score_entry_t;

    function automatic logic [31:0] chord_word(input score_entry_t e);
        return {12'h000, e.hush, e.notes};
    endfunction

endpackage

// File: rtl/score_sequencer_if.sv
// Score memory read port: sequencer issues enable/address, ROM answers one
// cycle later with the entry.
interface score_sequencer_if #(parameter int ADDR_W = 8);

    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data;

    modport master (output mem_en, output mem_addr, input mem_data);
    modport slave  (input mem_en, input mem_addr, output mem_data);

endinterface

// File: rtl/score_sequencer_tick_timer.sv
// Tempo prescaler plus duration down-counter; expire pulses on the last cycle
// of a D-tick hold so the sequencer can leave HOLD on the following edge.
module tick_timer #(
    parameter int TICK_CYCLES = 100000,
    parameter int DUR_W       = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             run,
    input  logic [DUR_W-1:0] dur,
    output logic             expire
);

    localparam int PRESC_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_CYCLES - 1);

    logic [PRESC_W-1:0] presc_reg;
    logic [DUR_W-1:0]   dur_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_reg <= '0;
            dur_reg   <= '0;
        end else if (load) begin
            presc_reg <= PRESC_MAX;
            // A zero duration still plays for one tick
            dur_reg   <= (dur == '0) ? DUR_W'(1) : dur;
        end else if (run) begin
            if (presc_reg == '0) begin
                presc_reg <= PRESC_MAX;
                dur_reg   <= dur_reg - 1'b1;
            end else begin
                presc_reg <= presc_reg - 1'b1;
            end
        end
    end

    assign expire = run && (presc_reg == '0) && (dur_reg == DUR_W'(1));

endmodule

// File: rtl/score_sequencer.sv
// Score sequencer: walks the score ROM entry by entry and drives the 32-bit
// piano control word, holding each chord for its programmed number of ticks.
module score_sequencer
    import score_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int TICK_CYCLES = 100000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      stop,
    score_sequencer_if.master         mem,
    output logic [31:0]               control,
    output logic                      busy,
    output logic                      done
);

    logic [1:0]        state_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       control_reg;
    logic              done_reg;
    logic              played_reg;

    score_entry_t entry;
    logic         tick_load;
    logic         tick_run;
    logic         tick_expire;

    assign entry     = mem.mem_data;
    assign tick_load = (state_reg == ST_LOAD) && (entry.op == OP_PLAY) && !stop;
    assign tick_run  = (state_reg == ST_HOLD);

    tick_timer #(
        .TICK_CYCLES (TICK_CYCLES),
        .DUR_W       (DUR_W)
    ) u_tick_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (tick_load),
        .run    (tick_run),
        .dur    (entry.dur),
        .expire (tick_expire)
    );

    assign mem.mem_en   = (state_reg == ST_FETCH);
    assign mem.mem_addr = addr_reg;
    assign control      = control_reg;
    assign busy         = (state_reg != ST_IDLE);
    assign done         = done_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            addr_reg    <= '0;
            control_reg <= SILENCE;
            done_reg    <= 1'b0;
            played_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (stop && (state_reg != ST_IDLE)) begin
                state_reg   <= ST_IDLE;
                addr_reg    <= '0;
                control_reg <= SILENCE;
                played_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (start && !stop) begin
                            state_reg  <= ST_FETCH;
                            addr_reg   <= '0;
                            played_reg <= 1'b0;
                        end
                    end
                    ST_FETCH: state_reg <= ST_LOAD;
                    ST_LOAD: begin
                        if (entry.op == OP_PLAY) begin
                            control_reg <= chord_word(entry);
                            addr_reg    <= addr_reg + 1'b1;
                            played_reg  <= 1'b1;
                            state_reg   <= ST_HOLD;
                        end else if ((entry.op == OP_LOOP) && played_reg) begin
                            addr_reg   <= '0;
                            played_reg <= 1'b0;
                            state_reg  <= ST_FETCH;
                        end else begin
                            // END, reserved op, or a LOOP with nothing played since the last one
                            control_reg <= SILENCE;
                            done_reg    <= 1'b1;
                            addr_reg    <= '0;
                            played_reg  <= 1'b0;
                            state_reg   <= ST_IDLE;
                        end
                    end
                    ST_HOLD: begin
                        if (tick_expire) begin
                            state_reg <= ST_FETCH;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_score_sequencer.sv
// Directed bench for score_sequencer: a timeline model expands the score ROM
// into expected per-cycle outputs, plus literal checks on key timings.
module tb_score_sequencer;
    import score_pkg::*;

    localparam int ADDR_W = 4;
    localparam int TICK   = 4;
    localparam int DEPTH  = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [31:0] control;
    logic        busy;
    logic        done;

    score_sequencer_if #(.ADDR_W(ADDR_W)) mif ();

    score_sequencer #(
        .ADDR_W      (ADDR_W),
        .TICK_CYCLES (TICK)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .stop    (stop),
        .mem     (mif),
        .control (control),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Synchronous-read score ROM
    logic [31:0] rom [DEPTH];
    always @(posedge clk) begin
        if (mif.mem_en) mif.mem_data <= rom[mif.mem_addr];
    end

    typedef struct {
        logic [31:0] control;
        bit          busy;
        bit          done;
        bit          en;
        int          addr;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          last_done_cyc = -1;
    int          fetch_addr[$];
    int          fetch_cyc[$];
    logic [31:0] obs_control;
    logic        obs_busy;

    function automatic logic [31:0] mk(input logic [1:0] op, input int dur,
                                       input logic [3:0] hush, input logic [15:0] notes);
        return {op, 10'(dur), hush, notes};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input logic [31:0] c, input bit b, input bit d, input bit e, input int a);
        exp_t x;
        x.control = c;
        x.busy    = b;
        x.done    = d;
        x.en      = e;
        x.addr    = a;
        exp_q.push_back(x);
    endtask

    // Expand the score from address 0 into the cycle-by-cycle output sequence
    task automatic build();
        int          a = 0;
        bit          played = 1'b0;
        logic [31:0] c = SILENCE;
        logic [31:0] e;
        int          d;
        while (exp_q.size() < 300) begin
            e = rom[a];
            push(c, 1'b1, 1'b0, 1'b1, a);
            push(c, 1'b1, 1'b0, 1'b0, a);
            if (e[31:30] == 2'b00) begin
                c = {12'h000, e[19:0]};
                d = (e[29:20] == 10'd0) ? 1 : int'(e[29:20]);
                repeat (d * TICK) push(c, 1'b1, 1'b0, 1'b0, 0);
                a = (a + 1) % DEPTH;
                played = 1'b1;
            end else if (e[31:30] == 2'b10 && played) begin
                a = 0;
                played = 1'b0;
            end else begin
                push(SILENCE, 1'b0, 1'b1, 1'b0, 0);
                break;
            end
        end
    endtask

    // One clock cycle: drive inputs for the next edge, compare at the falling edge
    task automatic step(input bit s, input bit p);
        exp_t cur;
        start = s;
        stop  = p;
        @(negedge clk);
        cyc++;
        if (!rst_n) exp_q.delete();
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
        end else begin
            cur.control = SILENCE;
            cur.busy    = 1'b0;
            cur.done    = 1'b0;
            cur.en      = 1'b0;
            cur.addr    = 0;
        end
        chk("control", control, cur.control);
        chk("busy", 32'(busy), 32'(cur.busy));
        chk("done", 32'(done), 32'(cur.done));
        chk("mem_en", 32'(mif.mem_en), 32'(cur.en));
        if (cur.en) chk("mem_addr", 32'(mif.mem_addr), 32'(cur.addr));
        obs_control = control;
        obs_busy    = busy;
        if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
        if (mif.mem_en) begin
            fetch_addr.push_back(int'(mif.mem_addr));
            fetch_cyc.push_back(cyc);
        end
        if (rst_n) begin
            if (p) begin
                if (cur.busy) exp_q.delete();
            end else if (s && !cur.busy) begin
                build();
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        int c0, d0, f0, first, hits, nonsil;
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        for (int i = 0; i < DEPTH; i++) rom[i] = mk(OP_END, 0, 4'h0, 16'h0000);

        // Reset state
        step(0, 0);
        step(0, 0);
        chk("reset_control", obs_control, 32'h000F_0000);
        chk("reset_busy", 32'(obs_busy), 32'd0);
        rst_n = 1'b1;
        step(0, 0);

        // Single chord: held through HOLD (12) plus fetch/load of the END entry
        rom[0] = mk(OP_PLAY, 3, 4'h0, 16'h4321);
        rom[1] = mk(OP_END, 0, 4'h0, 16'h0000);
        d0 = done_cnt;
        step(1, 0);
        c0 = cyc + 1;
        first = 0;
        hits = 0;
        for (int i = 1; i <= 22; i++) begin
            step(0, 0);
            if (obs_control == 32'h0000_4321) begin
                hits++;
                if (first == 0) first = i;
            end
        end
        chk("chord_first_cycle", 32'(first), 32'd3);
        chk("chord_cycles", 32'(hits), 32'd14);
        chk("chord_done_cycle", 32'(last_done_cyc), 32'(c0 + 16));
        chk("chord_done_count", 32'(done_cnt - d0), 32'd1);
        chk("chord_busy_after", 32'(obs_busy), 32'd0);

        // start during HOLD is ignored, timing unchanged
        d0 = done_cnt;
        step(1, 0);
        c0 = cyc + 1;
        for (int i = 1; i <= 25; i++) step(i == 6, 0);
        chk("restart_done_cycle", 32'(last_done_cyc), 32'(c0 + 16));
        chk("restart_done_count", 32'(done_cnt - d0), 32'd1);

        // Asynchronous reset in the middle of HOLD
        step(1, 0);
        for (int i = 1; i <= 6; i++) step(0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_control", control, 32'h000F_0000);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_mem_en", 32'(mif.mem_en), 32'd0);
        step(0, 0);
        rst_n = 1'b1;
        step(0, 0);

        // Empty loop behaves as END
        rom[0] = mk(OP_LOOP, 0, 4'h0, 16'h0000);
        d0 = done_cnt;
        step(1, 0);
        c0 = cyc + 1;
        nonsil = 0;
        for (int i = 1; i <= 6; i++) begin
            step(0, 0);
            if (obs_control != SILENCE) nonsil++;
        end
        chk("empty_done_cycle", 32'(last_done_cyc), 32'(c0 + 2));
        chk("empty_done_count", 32'(done_cnt - d0), 32'd1);
        chk("empty_control_silent", 32'(nonsil), 32'd0);

        // Loop: fetches 0,1,0,1..., no done, then stop
        rom[0] = mk(OP_PLAY, 1, 4'h0, 16'h0001);
        rom[1] = mk(OP_LOOP, 0, 4'h0, 16'h0000);
        d0 = done_cnt;
        f0 = fetch_addr.size();
        step(1, 0);
        for (int i = 1; i <= 40; i++) step(0, 0);
        for (int i = 0; i < 4; i++) chk("loop_fetch_addr", 32'(fetch_addr[f0 + i]), 32'(i % 2));
        chk("loop_busy", 32'(obs_busy), 32'd1);
        chk("loop_control", obs_control, 32'h0000_0001);
        step(0, 1);
        step(0, 0);
        chk("stop_control", obs_control, 32'h000F_0000);
        chk("stop_busy", 32'(obs_busy), 32'd0);
        for (int i = 0; i < 5; i++) step(0, 0);
        chk("loop_no_done", 32'(done_cnt - d0), 32'd0);

        // Sixteen D=0 entries: one tick each, address wraps 15 -> 0
        for (int i = 0; i < DEPTH; i++) rom[i] = mk(OP_PLAY, 0, 4'(i), 16'h0100 | 16'(i));
        f0 = fetch_addr.size();
        step(1, 0);
        for (int i = 1; i <= 110; i++) step(0, 0);
        chk("wrap_addr_15", 32'(fetch_addr[f0 + 15]), 32'd15);
        chk("wrap_addr_0", 32'(fetch_addr[f0 + 16]), 32'd0);
        chk("wrap_period", 32'(fetch_cyc[f0 + 16] - fetch_cyc[f0 + 15]), 32'd6);
        step(0, 1);
        step(0, 0);

        // start and stop together in IDLE: stays idle
        step(1, 1);
        step(0, 0);
        chk("start_stop_busy", 32'(obs_busy), 32'd0);
        step(0, 1);
        step(0, 0);
        chk("idle_stop_busy", 32'(obs_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
